mem_host_bridge: RTL and testbench

- Cache-line bridge between the core's refill/writeback port (`mem_*`) and the memory controller's host port (`host_*`).
- Acts as the host-side initiator for `ram_core`:
  - turns each 128-bit line request into one 8-beat, 16-bit `host_*` burst;
  - assembles read bursts into a line and returns it through `mem_replace`.
- Sits in `system` in place of the simulation memory model for synthesized builds.

---
 rtl/mem_host_bridge.sv | 176 +++++++++++++++++
 tb/tb_mem_host_bridge.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_host_bridge.sv
// mem_host_bridge: cache-line bridge from the core refill/writeback port
// (mem_*) to the memory controller host port (host_*).
// Each 128-bit line request becomes one 8-beat, 16-bit host burst; read
// bursts are assembled into a line and returned through mem_replace.
// Ports: clk, rst (sync, active-high); mem_request/rwn/partial/addr/
// commit/write_data in, mem_finish/replace/replace_set/tag/dat out;
// host_req/rwn/burst/addr/txm/txd out, host_ack/txd_ack/rxd/rxd_vld in;
// bus_err out (watchdog abort pulse).
// Optional feature macro: MEMBRIDGE_TIMEOUT_EN enables the watchdog.
module mem_host_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_request,
    input  logic         mem_rwn,
    input  logic         mem_partial,
    input  logic [15:0]  mem_addr,
    input  logic [15:0]  mem_commit,
    input  logic [127:0] mem_write_data,
    output logic         mem_finish,
    output logic         mem_replace,
    output logic [4:0]   mem_replace_set,
    output logic [6:0]   mem_replace_tag,
    output logic [127:0] mem_replace_dat,
    output logic         host_req,
    output logic         host_rwn,
    output logic         host_burst,
    output logic [31:0]  host_addr,
    input  logic         host_ack,
    output logic [1:0]   host_txm,
    output logic [15:0]  host_txd,
    input  logic         host_txd_ack,
    input  logic [15:0]  host_rxd,
    input  logic         host_rxd_vld,
    output logic         bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           rwn_q;
    logic [15:0]    addr_q;
    logic [15:0]    commit_q;
    logic [127:0]   data_q;
    logic [127:0]   line_q;
    logic [127:0]   line_nx;
    logic [2:0]     beat;
    logic           beat_acc;
    logic           last_beat;
    logic           busy;
    logic           timeout;
    logic           err_q;

    assign busy = (state == REQ) || (state == WDATA) || (state == RDATA);

    always_comb begin
        state_nx = state;
        beat_acc = 1'b0;
        line_nx  = line_q;
        line_nx[{beat, 4'h0} +: 16] = host_rxd;
        case (state)
            IDLE: begin
                if (mem_request) state_nx = REQ;
            end
            REQ: begin
                if (host_ack) state_nx = rwn_q ? RDATA : WDATA;
            end
            WDATA: begin
                if (host_txd_ack) begin
                    beat_acc = 1'b1;
                    if (beat == 3'd7) state_nx = DONE;
                end
            end
            RDATA: begin
                if (host_rxd_vld) begin
                    beat_acc = 1'b1;
                    if (beat == 3'd7) state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A watchdog abort overrides any progress made in the same cycle.
        if (timeout) state_nx = DONE;
    end

    assign last_beat = beat_acc && (beat == 3'd7) && (state == RDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            beat            <= 3'd0;
            rwn_q           <= 1'b1;
            addr_q          <= 16'h0;
            commit_q        <= 16'h0;
            data_q          <= 128'h0;
            line_q          <= 128'h0;
            host_addr       <= 32'h0;
            mem_replace_dat <= 128'h0;
            mem_replace_set <= 5'h0;
            mem_replace_tag <= 7'h0;
            err_q           <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mem_request) begin
                rwn_q     <= mem_rwn;
                addr_q    <= mem_addr;
                commit_q  <= mem_partial ? mem_commit : 16'hFFFF;
                data_q    <= mem_write_data;
                beat      <= 3'd0;
                host_addr <= BASE_ADDR + {16'h0, mem_addr, 4'h0};
                err_q     <= 1'b0;
            end
            if (beat_acc) begin
                beat   <= beat + 3'd1;
                line_q <= line_nx;
            end
            if (last_beat) begin
                mem_replace_dat <= line_nx;
                mem_replace_set <= addr_q[4:0];
                mem_replace_tag <= addr_q[11:5];
            end
            if (timeout) begin
                err_q <= 1'b1;
                // An aborted read still returns a line so the core never hangs.
                if (rwn_q) begin
                    mem_replace_dat <= '1;
                    mem_replace_set <= addr_q[4:0];
                    mem_replace_tag <= addr_q[11:5];
                end
            end
        end
    end

`ifdef MEMBRIDGE_TIMEOUT_EN
    logic [15:0] wd;

    assign timeout = busy && (wd == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd <= 16'h0;
        end else if (state_nx != state || beat_acc) begin
            wd <= 16'h0;
        end else if (busy) begin
            wd <= wd + 16'h1;
        end
    end

    assign bus_err = (state == DONE) && err_q;
`else
    logic unused_cfg;

    assign unused_cfg = busy ^ err_q ^ (^TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
`endif

    assign host_req    = (state == REQ);
    assign host_rwn    = rwn_q;
    assign host_burst  = 1'b1;
    assign host_txd    = data_q[{beat, 4'h0} +: 16];
    assign host_txm    = ~commit_q[{beat, 1'b0} +: 2];
    assign mem_finish  = (state == DONE);
    assign mem_replace = (state == DONE) && rwn_q;

endmodule

// File: tb/tb_mem_host_bridge.sv
// tb_mem_host_bridge: directed, table-driven bench for mem_host_bridge.
// Line transactions from a vector table plus hand-written corner cases.
module tb_mem_host_bridge;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_request;
    logic         mem_rwn;
    logic         mem_partial;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_commit;
    logic [127:0] mem_write_data;
    logic         mem_finish;
    logic         mem_replace;
    logic [4:0]   mem_replace_set;
    logic [6:0]   mem_replace_tag;
    logic [127:0] mem_replace_dat;
    logic         host_req;
    logic         host_rwn;
    logic         host_burst;
    logic [31:0]  host_addr;
    logic         host_ack;
    logic [1:0]   host_txm;
    logic [15:0]  host_txd;
    logic         host_txd_ack;
    logic [15:0]  host_rxd;
    logic         host_rxd_vld;
    logic         bus_err;

    mem_host_bridge #(
        .BASE_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_request     (mem_request),
        .mem_rwn         (mem_rwn),
        .mem_partial     (mem_partial),
        .mem_addr        (mem_addr),
        .mem_commit      (mem_commit),
        .mem_write_data  (mem_write_data),
        .mem_finish      (mem_finish),
        .mem_replace     (mem_replace),
        .mem_replace_set (mem_replace_set),
        .mem_replace_tag (mem_replace_tag),
        .mem_replace_dat (mem_replace_dat),
        .host_req        (host_req),
        .host_rwn        (host_rwn),
        .host_burst      (host_burst),
        .host_addr       (host_addr),
        .host_ack        (host_ack),
        .host_txm        (host_txm),
        .host_txd        (host_txd),
        .host_txd_ack    (host_txd_ack),
        .host_rxd        (host_rxd),
        .host_rxd_vld    (host_rxd_vld),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rwn;
        logic         partial;
        logic [15:0]  addr;
        logic [15:0]  commit;
        logic [127:0] line;
        logic [31:0]  exp_addr;
        logic [15:0]  exp_txm;
        logic [4:0]   exp_set;
        logic [6:0]   exp_tag;
    } vec_t;

    vec_t         tbl[5];
    int           checks = 0;
    int           failures = 0;
    logic [127:0] last_rd = 128'h0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (host_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input int i);
        bit ok;
        vec_t v;
        v = tbl[i];
        @(negedge clk);
        mem_request    = 1'b1;
        mem_rwn        = v.rwn;
        mem_partial    = v.partial;
        mem_addr       = v.addr;
        mem_commit     = v.commit;
        mem_write_data = v.line;
        @(negedge clk);
        wait_req(ok);
        chk($sformatf("t%0d_req", i), 128'(ok), 128'd1);
        chk($sformatf("t%0d_addr", i), 128'(host_addr), 128'(v.exp_addr));
        chk($sformatf("t%0d_rwn", i), 128'(host_rwn), 128'(v.rwn));
        chk($sformatf("t%0d_burst", i), 128'(host_burst), 128'd1);
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        chk($sformatf("t%0d_req_drop", i), 128'(host_req), 128'd0);
        for (int b = 0; b < 8; b++) begin
            if (v.rwn) begin
                host_rxd_vld = 1'b1;
                host_rxd     = v.line[16*b +: 16];
            end else begin
                chk($sformatf("t%0d_txd%0d", i, b), 128'(host_txd),
                    128'(v.line[16*b +: 16]));
                chk($sformatf("t%0d_txm%0d", i, b), 128'(host_txm),
                    128'(v.exp_txm[2*b +: 2]));
                host_txd_ack = 1'b1;
            end
            @(negedge clk);
        end
        host_txd_ack = 1'b0;
        host_rxd_vld = 1'b0;
        chk($sformatf("t%0d_finish", i), 128'(mem_finish), 128'd1);
        chk($sformatf("t%0d_replace", i), 128'(mem_replace), 128'(v.rwn));
        if (v.rwn) begin
            chk($sformatf("t%0d_dat", i), mem_replace_dat, v.line);
            chk($sformatf("t%0d_set", i), 128'(mem_replace_set),
                128'(v.exp_set));
            chk($sformatf("t%0d_tag", i), 128'(mem_replace_tag),
                128'(v.exp_tag));
            last_rd = v.line;
        end else begin
            chk($sformatf("t%0d_hold", i), mem_replace_dat, last_rd);
        end
        mem_request = 1'b0;
        @(negedge clk);
        chk($sformatf("t%0d_finish_pulse", i), 128'(mem_finish), 128'd0);
    endtask

    initial begin : main
        bit           ok;
        int           cnt;
        logic [127:0] c_line;

        tbl[0] = '{1'b1, 1'b0, 16'h0123, 16'h0000,
                   128'h7700_6700_6600_5500_4400_3300_2200_1100,
                   32'h0000_1230, 16'hFFFF, 5'h03, 7'h09};
        tbl[1] = '{1'b0, 1'b0, 16'hABCD, 16'h1234,
                   128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100,
                   32'h000A_BCD0, 16'h0000, 5'h00, 7'h00};
        tbl[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h00F0,
                   128'h1111_2222_3333_4444_5555_6666_7777_8888,
                   32'h000F_FFF0, 16'hFF0F, 5'h00, 7'h00};
        tbl[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000,
                   128'hA5A5_0001_FFFF_8000_1234_5678_9ABC_DEF0,
                   32'h000F_FFF0, 16'hFFFF, 5'h1F, 7'h7F};
        tbl[4] = '{1'b0, 1'b1, 16'h0040, 16'h8001,
                   128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF,
                   32'h0000_0400, 16'h7FFE, 5'h00, 7'h00};

        rst = 1'b1;
        mem_request = 1'b0;
        mem_rwn = 1'b1;
        mem_partial = 1'b0;
        mem_addr = 16'h0;
        mem_commit = 16'h0;
        mem_write_data = 128'h0;
        host_ack = 1'b0;
        host_txd_ack = 1'b0;
        host_rxd = 16'h0;
        host_rxd_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_finish", 128'(mem_finish), 128'd0);
        chk("rst_replace", 128'(mem_replace), 128'd0);
        chk("rst_req", 128'(host_req), 128'd0);
        chk("rst_err", 128'(bus_err), 128'd0);
        chk("rst_rwn", 128'(host_rwn), 128'd1);
        chk("rst_burst", 128'(host_burst), 128'd1);
        chk("rst_txm", 128'(host_txm), 128'd3);
        chk("rst_addr", 128'(host_addr), 128'd0);
        chk("rst_txd", 128'(host_txd), 128'd0);
        chk("rst_dat", mem_replace_dat, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn(i);
            if (i == 0) begin
                chk("t0_dat_lo", 128'(mem_replace_dat[15:0]), 128'h1100);
                chk("t0_dat_hi", 128'(mem_replace_dat[127:112]), 128'h7700);
            end
        end

        // vld with ack is ignored, ack late, request held through DONE
        c_line = 128'h8008_7007_6006_5005_4004_3003_2002_1001;
        @(negedge clk);
        mem_request = 1'b1;
        mem_rwn = 1'b1;
        mem_addr = 16'h0321;
        @(negedge clk);
        wait_req(ok);
        chk("c1_req", 128'(ok), 128'd1);
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("c1_req_hold%0d", n), 128'(host_req), 128'd1);
            @(negedge clk);
        end
        host_ack = 1'b1;
        host_rxd_vld = 1'b1;
        host_rxd = 16'hDEAD;
        @(negedge clk);
        host_ack = 1'b0;
        host_rxd_vld = 1'b0;
        chk("c1_req_drop", 128'(host_req), 128'd0);
        for (int b = 0; b < 8; b++) begin
            host_rxd_vld = 1'b1;
            host_rxd = c_line[16*b +: 16];
            @(negedge clk);
        end
        host_rxd_vld = 1'b0;
        chk("c1_finish", 128'(mem_finish), 128'd1);
        chk("c1_dat", mem_replace_dat, c_line);
        chk("c1_set", 128'(mem_replace_set), 128'h01);
        chk("c1_tag", 128'(mem_replace_tag), 128'h19);
        @(negedge clk);
        chk("c1_finish_pulse", 128'(mem_finish), 128'd0);
        mem_request = 1'b0;
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (host_req || mem_finish) cnt++;
        end
        chk("c1_single_txn", 128'(cnt), 128'd0);
        chk("c1_dat_hold", mem_replace_dat, c_line);

        // reset during beat 4 of a read
        mem_request = 1'b1;
        mem_rwn = 1'b1;
        mem_addr = 16'h0040;
        @(negedge clk);
        wait_req(ok);
        chk("c2_req", 128'(ok), 128'd1);
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            host_rxd_vld = 1'b1;
            host_rxd = 16'h5A00 + 16'(b);
            if (b == 4) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        host_rxd_vld = 1'b0;
        mem_request = 1'b0;
        chk("c2_req0", 128'(host_req), 128'd0);
        chk("c2_finish0", 128'(mem_finish), 128'd0);
        chk("c2_replace0", 128'(mem_replace), 128'd0);
        chk("c2_addr0", 128'(host_addr), 128'd0);
        chk("c2_rwn1", 128'(host_rwn), 128'd1);
        chk("c2_txm3", 128'(host_txm), 128'd3);
        chk("c2_dat0", mem_replace_dat, 128'd0);
        chk("c2_set0", 128'(mem_replace_set), 128'd0);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_finish || host_req) cnt++;
        end
        chk("c2_no_finish", 128'(cnt), 128'd0);
        run_txn(3);

`ifdef MEMBRIDGE_TIMEOUT_EN
        // host_ack never arrives: watchdog abort
        @(negedge clk);
        mem_request = 1'b1;
        mem_rwn = 1'b1;
        mem_addr = 16'h0010;
        @(negedge clk);
        chk("c3_req", 128'(host_req), 128'd1);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (mem_finish) break;
            @(negedge clk);
            cnt++;
        end
        chk("c3_latency", 128'(cnt), 128'd17);
        chk("c3_err", 128'(bus_err), 128'd1);
        chk("c3_replace", 128'(mem_replace), 128'd1);
        chk("c3_dat", mem_replace_dat, {128{1'b1}});
        mem_request = 1'b0;
        @(negedge clk);
        chk("c3_err_pulse", 128'(bus_err), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
